fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'hE1A0_0000: instruction word inserted on bubbles and flushes.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 freeze  input  1  hazard stall from hazard unit; holds the IF/ID outputs.
REQ-006 branch_taken  input  1  redirect from EX stage, single-cycle pulse.
REQ-007 branch_addr  input  32  redirect target; valid only when branch_taken=1.
REQ-008 imem_req  output  1  instruction memory request, registered.
REQ-009 imem_addr  output  32  request address; stable while imem_req=1.
REQ-010 imem_ack  input  1  memory response valid; sampled only while imem_req=1.
REQ-011 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-012 instr_out  output  32  IF/ID instruction to decode.
REQ-013 pc_out  output  32  IF/ID PC, equal to fetch address + 4.
REQ-014 valid_out  output  1  instr_out/pc_out carry a real instruction.

Function
REQ-015 FSM states IDLE, WAIT, SQUASH, HOLD shall exist; imem_req=1 exactly in WAIT and SQUASH.
REQ-016 IDLE: branch_taken -> imem_addr<=branch_addr, WAIT; else !freeze -> WAIT with imem_addr unchanged; else stay in IDLE.
REQ-017 WAIT, branch_taken & imem_ack: data discarded, imem_addr<=branch_addr, stay in WAIT.
REQ-018 WAIT, branch_taken & !imem_ack: redirect register<=branch_addr, go to SQUASH; imem_addr unchanged.
REQ-019 WAIT, imem_ack & !freeze & !branch_taken: deliver (REQ-024), imem_addr<=imem_addr+4, stay in WAIT (zero-wait memory yields 1 instruction/cycle).
REQ-020 WAIT, imem_ack & freeze & !branch_taken: hold buffer<=imem_rdata, go to HOLD; imem_addr unchanged.
REQ-021 SQUASH: imem_ack -> data discarded, imem_addr<=redirect, go to WAIT; branch_taken in SQUASH overwrites the redirect register (latest wins); if it coincides with imem_ack, imem_addr<=branch_addr.
REQ-022 HOLD: branch_taken -> buffer discarded, imem_addr<=branch_addr, go to WAIT; else !freeze -> deliver the buffer, imem_addr<=imem_addr+4, go to WAIT; else stay in HOLD.
REQ-023 imem_addr arithmetic shall be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-024 Deliver: instr_out<=word, pc_out<=imem_addr+4, valid_out<=1 on the next edge.
REQ-025 IF/ID update priority shall be branch_taken > freeze > deliver > bubble.
REQ-026 branch_taken: instr_out<=NOP_INSTR, pc_out<=0, valid_out<=0, regardless of freeze.
REQ-027 freeze (no branch): instr_out, pc_out, valid_out hold.
REQ-028 Bubble (no delivery, no freeze, no branch): instr_out<=NOP_INSTR, valid_out<=0, pc_out holds.
REQ-029 A discarded response shall never reach instr_out.
REQ-030 imem_ack while imem_req=0 shall be ignored.

Reset
REQ-031 rst=0 shall immediately force state IDLE, imem_req=0, imem_addr=RESET_PC, instr_out=NOP_INSTR, pc_out=0, valid_out=0, squash/hold contents cleared.
REQ-032 Reset mid-request shall abandon the outstanding request; a late imem_ack after release shall be ignored per REQ-030.
REQ-033 The first request shall be issued in the second cycle after rst rises (IDLE -> WAIT).

Verification
REQ-034 Zero-wait memory (ack every cycle, rdata=addr^32'hA5A5_0000), no stalls -> imem_addr 0,4,8,...; pc_out 4,8,12,...; valid_out=1 every cycle after the first delivery.
REQ-035 2-cycle-latency memory -> alternating valid_out 1/0; instr_out=NOP_INSTR on bubble cycles.
REQ-036 freeze asserted for 3 cycles during ack of addr 8 -> HOLD; outputs unchanged for 3 cycles; then instr@8 with pc_out=12 delivered; next request at 12.
REQ-037 branch_taken to 32'h100 while request for 16 is outstanding without ack -> SQUASH; ack for 16 discarded; next request at 32'h100; first valid output pc_out=32'h104.
REQ-038 branch_taken together with freeze and ack -> valid_out=0, pc_out=0, instr_out=NOP_INSTR; next imem_addr=branch_addr.
REQ-039 rst pulsed low while in WAIT at addr 20 -> outputs equal reset values immediately; refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a request/ack instruction memory and fills the IF/ID register.
// Branch redirects squash in-flight responses; a hazard freeze parks an early response in a hold buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        req_reg, req_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] redirect_reg, redirect_next;
    logic [31:0] hold_reg, hold_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_reg, pc_next;
    logic        valid_reg, valid_next;

    logic        deliver;
    logic [31:0] deliver_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            req_reg      <= 1'b0;
            addr_reg     <= RESET_PC;
            redirect_reg <= 32'h0;
            hold_reg     <= 32'h0;
            instr_reg    <= NOP_INSTR;
            pc_reg       <= 32'h0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            addr_reg     <= addr_next;
            redirect_reg <= redirect_next;
            hold_reg     <= hold_next;
            instr_reg    <= instr_next;
            pc_reg       <= pc_next;
            valid_reg    <= valid_next;
        end
    end

    // Fetch sequencing; imem_ack is only looked at in the two requesting states.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        redirect_next = redirect_reg;
        hold_next     = hold_reg;
        deliver       = 1'b0;
        deliver_word  = hold_reg;

        case (state_reg)
            IDLE: begin
                if (branch_taken) begin
                    addr_next  = branch_addr;
                    state_next = WAIT;
                end else if (!freeze) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    if (imem_ack) begin
                        addr_next = branch_addr;
                    end else begin
                        redirect_next = branch_addr;
                        state_next    = SQUASH;
                    end
                end else if (imem_ack) begin
                    if (!freeze) begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                        addr_next    = addr_reg + 32'd4;
                    end else begin
                        hold_next  = imem_rdata;
                        state_next = HOLD;
                    end
                end
            end
            SQUASH: begin
                // The response still owed for the old address is dropped.
                if (branch_taken) begin
                    redirect_next = branch_addr;
                end
                if (imem_ack) begin
                    addr_next  = branch_taken ? branch_addr : redirect_reg;
                    state_next = WAIT;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    addr_next  = branch_addr;
                    state_next = WAIT;
                end else if (!freeze) begin
                    deliver      = 1'b1;
                    deliver_word = hold_reg;
                    addr_next    = addr_reg + 32'd4;
                    state_next   = WAIT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_next = (state_next == WAIT) || (state_next == SQUASH);

    // IF/ID register: branch beats freeze beats deliver beats bubble.
    always_comb begin
        instr_next = instr_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        if (branch_taken) begin
            instr_next = NOP_INSTR;
            pc_next    = 32'h0;
            valid_next = 1'b0;
        end else if (freeze) begin
            instr_next = instr_reg;
        end else if (deliver) begin
            instr_next = deliver_word;
            pc_next    = addr_reg + 32'd4;
            valid_next = 1'b1;
        end else begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end
    end

    assign imem_req  = req_reg;
    assign imem_addr = addr_reg;
    assign instr_out = instr_reg;
    assign pc_out    = pc_reg;
    assign valid_out = valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait and 2-cycle memory, freeze/hold,
// squash on redirect, branch+freeze+ack, mid-request reset and address wraparound.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'hE1A0_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;

    int n_vec = 0;
    int n_bad = 0;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .valid_out    (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("  ok %s = 0x%08h", tag, got);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc, input logic valid);
        check_val({tag, ".instr"}, instr_out, instr);
        check_val({tag, ".pc"}, pc_out, pc);
        check_val({tag, ".valid"}, {31'h0, valid_out}, {31'h0, valid});
    endtask

    task automatic check_fetch(input string tag, input logic req, input logic [31:0] addr);
        check_val({tag, ".req"}, {31'h0, imem_req}, {31'h0, req});
        check_val({tag, ".addr"}, imem_addr, addr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT one edge after release: first request at RESET_PC outstanding.
    task automatic apply_reset();
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        branch_addr = 32'h0; imem_rdata = 32'h0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        #12;
        check_fetch("reset", 1'b0, 32'h0);
        check_ifid("reset", NOP, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        check_fetch("release", 1'b0, 32'h0);
        tick();
        check_fetch("first_req", 1'b1, 32'h0);
        check_ifid("first_req", NOP, 32'h0, 1'b0);

        // Zero-wait memory: one instruction per cycle.
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            imem_rdata = word_at(32'(4 * i));
            tick();
            check_fetch("zw", 1'b1, 32'(4 * (i + 1)));
            check_ifid("zw", word_at(32'(4 * i)), 32'(4 * (i + 1)), 1'b1);
        end

        // Reset while waiting on address 20, then a late ack in IDLE.
        imem_ack = 1'b0;
        tick();
        check_fetch("wait20", 1'b1, 32'd20);
        check_val("wait20.valid", {31'h0, valid_out}, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check_fetch("midrst", 1'b0, 32'h0);
        check_ifid("midrst", NOP, 32'h0, 1'b0);
        imem_ack = 1'b1; imem_rdata = JUNK;
        tick();
        rst = 1'b1;
        tick();
        check_fetch("late_ack", 1'b1, 32'h0);
        check_ifid("late_ack", NOP, 32'h0, 1'b0);
        imem_rdata = word_at(32'h0);
        tick();
        check_ifid("refetch", word_at(32'h0), 32'd4, 1'b1);

        // Two-cycle memory: valid alternates, NOP on bubbles.
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b0;
            tick();
            check_ifid("lat2_bub", NOP, 32'(4 * i), 1'b0);
            check_val("lat2_bub.addr", imem_addr, 32'(4 * i));
            imem_ack = 1'b1; imem_rdata = word_at(32'(4 * i));
            tick();
            check_ifid("lat2_dlv", word_at(32'(4 * i)), 32'(4 * i + 4), 1'b1);
        end

        // Freeze for three cycles while address 8 is acked.
        apply_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            imem_rdata = word_at(32'(4 * i));
            tick();
        end
        imem_rdata = word_at(32'd8); freeze = 1'b1;
        tick();
        check_fetch("hold0", 1'b0, 32'd8);
        check_ifid("hold0", word_at(32'd4), 32'd8, 1'b1);
        imem_rdata = JUNK;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_fetch("hold", 1'b0, 32'd8);
            check_ifid("hold", word_at(32'd4), 32'd8, 1'b1);
        end
        freeze = 1'b0; imem_ack = 1'b0;
        tick();
        check_ifid("unhold", word_at(32'd8), 32'd12, 1'b1);
        check_fetch("unhold", 1'b1, 32'd12);

        // Redirect to 0x100 while address 16 is outstanding.
        apply_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = word_at(32'(4 * i));
            tick();
        end
        imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
        tick();
        check_fetch("squash", 1'b1, 32'd16);
        check_ifid("squash", NOP, 32'h0, 1'b0);
        branch_taken = 1'b0; imem_ack = 1'b1; imem_rdata = word_at(32'd16);
        tick();
        check_fetch("squash_ack", 1'b1, 32'h100);
        check_ifid("squash_ack", NOP, 32'h0, 1'b0);
        imem_rdata = word_at(32'h100);
        tick();
        check_ifid("redir", word_at(32'h100), 32'h104, 1'b1);
        check_val("redir.addr", imem_addr, 32'h104);

        // Two redirects in a row while squashing: the later target wins.
        imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h300;
        tick();
        branch_addr = 32'h400;
        tick();
        check_fetch("sq_again", 1'b1, 32'h104);
        branch_taken = 1'b0; imem_ack = 1'b1; imem_rdata = JUNK;
        tick();
        check_fetch("latest", 1'b1, 32'h400);
        check_ifid("latest", NOP, 32'h0, 1'b0);

        // Branch with freeze and ack together.
        imem_rdata = word_at(32'h400);
        tick();
        check_ifid("pre_bfa", word_at(32'h400), 32'h404, 1'b1);
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h500; imem_rdata = JUNK;
        tick();
        check_ifid("bfa", NOP, 32'h0, 1'b0);
        check_fetch("bfa", 1'b1, 32'h500);

        // Address wraps modulo 2^32.
        freeze = 1'b0; branch_addr = 32'hFFFF_FFFC;
        tick();
        check_fetch("to_top", 1'b1, 32'hFFFF_FFFC);
        branch_taken = 1'b0; imem_rdata = word_at(32'hFFFF_FFFC);
        tick();
        check_ifid("wrap", word_at(32'hFFFF_FFFC), 32'h0, 1'b1);
        check_fetch("wrap", 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
